// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG front-end blocks.
//   scan_state_t : block scan controller FSM states
//   BLOCK_DIM    : DCT block edge length in pixels
//   LEVEL_SHIFT  : offset removed from unsigned 8-bit samples before the DCT
package jpeg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int BLOCK_DIM   = 8;
  localparam int LEVEL_SHIFT = 128;

endpackage

// File: rtl/block_addr_gen.sv
// Block-order address generator.
// Walks col c (fastest), row r, block column bx, block row by, and presents
// the linear raster frame-buffer address of the current pixel.
// Ports:
//   Clock, Reset_n   clock / asynchronous active-low reset
//   clear            synchronous return of all counters to the frame origin
//   advance          step to the next pixel in block order
//   addr             linear address of the current pixel (combinational)
//   row_last         current pixel is column 7 of its block row
//   blk_last         current pixel is row 7, column 7 of its block
//   frame_last       current pixel is the last one of the frame
module block_addr_gen
  import jpeg_pkg::*;
#(
  parameter int IMG_W_BLK = 80,
  parameter int IMG_H_BLK = 60,
  parameter int ADDR_W    = 19
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              row_last,
  output logic              blk_last,
  output logic              frame_last
);

  // A single-block dimension still needs a 1-bit counter to stay legal.
  localparam int BX_W = (IMG_W_BLK > 1) ? $clog2(IMG_W_BLK) : 1;
  localparam int BY_W = (IMG_H_BLK > 1) ? $clog2(IMG_H_BLK) : 1;

  localparam logic [BX_W-1:0]   BX_MAX    = BX_W'(IMG_W_BLK - 1);
  localparam logic [BY_W-1:0]   BY_MAX    = BY_W'(IMG_H_BLK - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W_BLK * BLOCK_DIM);

  logic [2:0]      c;
  logic [2:0]      r;
  logic [BX_W-1:0] bx;
  logic [BY_W-1:0] by;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      c  <= '0;
      r  <= '0;
      bx <= '0;
      by <= '0;
    end else if (clear) begin
      c  <= '0;
      r  <= '0;
      bx <= '0;
      by <= '0;
    end else if (advance) begin
      c <= c + 3'd1;
      if (c == 3'd7) begin
        r <= r + 3'd1;
        if (r == 3'd7) begin
          if (bx == BX_MAX) begin
            bx <= '0;
            by <= (by == BY_MAX) ? '0 : by + BY_W'(1);
          end else begin
            bx <= bx + BX_W'(1);
          end
        end
      end
    end
  end

  assign row_last   = (c == 3'd7);
  assign blk_last   = row_last && (r == 3'd7);
  assign frame_last = blk_last && (bx == BX_MAX) && (by == BY_MAX);

  // {by,r} is the image line, {bx,c} the image column (both times 8 + offset).
  logic [BY_W+2:0] line_idx;
  logic [BX_W+2:0] col_idx;

  assign line_idx = {by, r};
  assign col_idx  = {bx, c};
  assign addr     = ADDR_W'(line_idx) * ROW_PITCH + ADDR_W'(col_idx);

endmodule

// File: rtl/block_scan_controller.sv
// Block scan controller: reads a stored image from the frame buffer in 8x8
// block order and streams level-shifted signed pixels to the row receiver.
// Ports:
//   Clock, Reset_n   clock / asynchronous active-low reset
//   Start            pulse, begins a frame scan when idle
//   Abort            level, ends the scan at the next block-row boundary
//   Ready_In         downstream ready; low suppresses new reads
//   Busy             scan in progress (Start accept until IDLE)
//   Mem_Rd_En        frame-buffer read strobe
//   Mem_Addr         frame-buffer read address
//   Mem_Data         read data, one cycle after Mem_Rd_En
//   Pixel_Out        signed pixel (Mem_Data - 2^(WIDTH-1))
//   Pixel_En         Pixel_Out valid
//   Row_Last         with Pixel_En: last pixel of a block row
//   Block_Last       with Pixel_En: last pixel of a block
//   Frame_Done       pulse, cycle after the final pixel of a complete frame
module block_scan_controller
  import jpeg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMG_W_BLK = 80,
  parameter int IMG_H_BLK = 60,
  parameter int ADDR_W    = 19
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic                    Ready_In,
  output logic                    Busy,
  output logic                    Mem_Rd_En,
  output logic [ADDR_W-1:0]       Mem_Addr,
  input  logic [WIDTH-1:0]        Mem_Data,
  output logic signed [WIDTH-1:0] Pixel_Out,
  output logic                    Pixel_En,
  output logic                    Row_Last,
  output logic                    Block_Last,
  output logic                    Frame_Done
);

  // Flipping the MSB subtracts 2^(WIDTH-1) from an unsigned sample.
  function automatic logic signed [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d);
    return {~d[WIDTH-1], d[WIDTH-2:0]};
  endfunction

  scan_state_t state;

  logic              issue;
  logic              clear;
  logic [ADDR_W-1:0] addr;
  logic              row_last;
  logic              blk_last;
  logic              frame_last;

  assign issue = (state == SCAN) && Ready_In;
  assign clear = (state == IDLE) && Start;

  block_addr_gen #(
    .IMG_W_BLK (IMG_W_BLK),
    .IMG_H_BLK (IMG_H_BLK),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .clear      (clear),
    .advance    (issue),
    .addr       (addr),
    .row_last   (row_last),
    .blk_last   (blk_last),
    .frame_last (frame_last)
  );

  logic vld_p0, rl_p0, bl_p0, fl_p0;
  logic vld_p1, rl_p1, bl_p1, fl_p1;
  logic fl_p2;

  assign Mem_Rd_En = vld_p0;

  // Stage p0: read issue (FSM, address and flags registered together)
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      vld_p0   <= 1'b0;
      Mem_Addr <= '0;
      rl_p0    <= 1'b0;
      bl_p0    <= 1'b0;
      fl_p0    <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= SCAN;
            Busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (Ready_In) begin
            vld_p0   <= 1'b1;
            Mem_Addr <= addr;
            rl_p0    <= row_last;
            bl_p0    <= blk_last;
            fl_p0    <= frame_last;
            // Abort is honoured only once a whole block row has been issued.
            if (frame_last || (row_last && Abort)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: state <= DONE;
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: memory data returning; Stage p2: pixel out
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1     <= 1'b0;
      rl_p1      <= 1'b0;
      bl_p1      <= 1'b0;
      fl_p1      <= 1'b0;
      Pixel_En   <= 1'b0;
      Row_Last   <= 1'b0;
      Block_Last <= 1'b0;
      fl_p2      <= 1'b0;
      Pixel_Out  <= '0;
      Frame_Done <= 1'b0;
    end else begin
      vld_p1     <= vld_p0;
      rl_p1      <= vld_p0 & rl_p0;
      bl_p1      <= vld_p0 & bl_p0;
      fl_p1      <= vld_p0 & fl_p0;
      Pixel_En   <= vld_p1;
      Row_Last   <= rl_p1;
      Block_Last <= bl_p1;
      fl_p2      <= fl_p1;
      if (vld_p1) begin
        Pixel_Out <= level_shift(Mem_Data);
      end
      // Only a scan that reached the final pixel ever carries fl_p2.
      Frame_Done <= Pixel_En & fl_p2;
    end
  end

endmodule
